pattern_serializer: RTL and testbench
=====================================

PATTERN_SERIALIZER -- requirements
Module: pattern_serializer

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the width of the parallel input word (legal range 2..32).
REQ-002 Parameter MSB_FIRST, default 1, SHALL select the serial bit order (1 = bit WIDTH-1 first, 0 = bit 0 first).
REQ-003 clk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 data_in  input  WIDTH  SHALL carry the parallel word offered by the upstream source.
REQ-006 data_valid  input  1  SHALL indicate that data_in holds a word.
REQ-007 data_ready  output  1  SHALL indicate that the block can accept a word this cycle.
REQ-008 hold  input  1  SHALL pause serial output while high.
REQ-009 d_out  output  1  SHALL be the serial data bit, which feeds the pattern detector's d_in.
REQ-010 valid_out  output  1  SHALL qualify d_out, which feeds the pattern detector's valid_in.
REQ-011 busy  output  1  SHALL be high while any word is held or being shifted.

Function
REQ-012 The block SHALL contain a one-word holding register with a full flag, a WIDTH-bit shift register, a bit counter, and a state register with two states, IDLE and SHIFT.
REQ-013 data_ready SHALL equal the inverted hold-full flag and SHALL be decoded from registers only, with no combinational path from data_valid.
REQ-014 A word SHALL be accepted on an edge where data_valid and data_ready are both 1; at that edge it is stored in the holding register and the full flag is set.
REQ-015 IDLE with hold-full set SHALL, on the next edge, move the word into the shift register, clear the full flag, zero the bit counter, and enter SHIFT, regardless of hold.
REQ-016 Latency SHALL be: word accepted at edge N; its first bit appears on d_out with valid_out=1 in the cycle after edge N+1, provided hold=0.
REQ-017 In SHIFT, valid_out SHALL be 1 when hold=0, and 0 otherwise.
REQ-018 In SHIFT, d_out SHALL be the current output-end bit of the shift register: bit WIDTH-1 when MSB_FIRST=1, bit 0 when MSB_FIRST=0.
REQ-019 In IDLE, valid_out SHALL be 0 and d_out SHALL be 0.
REQ-020 Each SHIFT edge with hold=0 SHALL shift the register by one toward the output end, filling with 0, and increment the bit counter.
REQ-021 When an edge with hold=0 occurs at bit counter = WIDTH-1, the block SHALL take one of two actions:
- if hold-full is set: load the held word, clear the full flag, zero the counter, and stay in SHIFT, so the next word follows with no idle cycle;
- if hold-full is clear: return to IDLE.
REQ-022 With hold=1, the shift register, bit counter and state SHALL be frozen, while the holding register SHALL still accept a word per REQ-014.
REQ-023 Accept and move never coincide, because acceptance needs the full flag clear and a move needs it set; in any cycle the block SHALL therefore either accept a word or move a word, never both.
REQ-024 data_in SHALL be ignored while data_valid=0 or data_ready=0.
REQ-025 busy SHALL equal (state==SHIFT) OR hold-full.
REQ-026 Exactly WIDTH valid_out=1 cycles SHALL be produced per accepted word; no bit may be dropped or duplicated, including across hold pauses.

Reset
REQ-027 While reset=1, the outputs SHALL be d_out=0, valid_out=0, busy=0 and data_ready=0, the state SHALL be IDLE, and the full flag, shift register and counter SHALL be 0.
REQ-028 data_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-029 Reset asserted mid-operation SHALL discard both the held word and the word in flight immediately (asynchronously); the block SHALL emit no partial word after release.

Verification
REQ-030 Single word: accept 8'hB4 at edge N with hold=0 -> d_out sequence 1,0,1,1,0,1,0,0 with valid_out=1 over edges N+2..N+9, then IDLE, busy=0.
REQ-031 Back-to-back words: offer 8'hFF then 8'h00 with data_valid held high -> 16 consecutive valid_out=1 cycles, bits 8×1 then 8×0, no gap.
REQ-032 Hold: apply hold=1 for 3 cycles after the 3rd bit of 8'hA5 -> valid_out=0 for those 3 cycles; the full serial stream is still 1,0,1,0,0,1,0,1.
REQ-033 LSB-first (MSB_FIRST=0): send 8'h01 -> first valid bit is 1, followed by seven 0s.
REQ-034 Reset mid-word: assert reset after 4 bits of 8'hC3 with a second word held -> valid_out=0 immediately; after release no bits are emitted and data_ready=1.
REQ-035 Random stream: 540 random bytes with random hold -> the serialized stream matches a reference bit queue, and a connected pattern detector's match count equals the golden-model count.

Source files
------------

// File: rtl/pattern_serializer.sv
// -----------------------------------------------------------------------------
// pattern_serializer
//
// Accepts parallel words through a valid/ready handshake into a one-word
// holding register, then shifts each word out one bit per un-held cycle on
// d_out/valid_out. The serial stream is intended to feed a pattern
// detector's d_in/valid_in pair. A word waiting in the holding register is
// loaded as soon as the previous word's last bit leaves, so consecutive
// words form a gap-free stream.
//
// Parameters
//   WIDTH      parallel word width (2..32)
//   MSB_FIRST  1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
//
// Ports
//   clk         single clock, rising-edge active
//   reset       asynchronous, active-high reset
//   data_in     parallel word from upstream
//   data_valid  data_in holds a word
//   data_ready  holding register is empty and can take a word this cycle
//   hold        pauses the serial output while high
//   d_out       serial data bit (0 when idle)
//   valid_out   qualifies d_out
//   busy        a word is held or being shifted
// -----------------------------------------------------------------------------
module pattern_serializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    input  logic             hold,
    output logic             d_out,
    output logic             valid_out,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] WORD_ZERO = {WIDTH{1'b0}};

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // State and datapath registers
    logic [0:0]       state_r;
    logic             full_r;
    logic [WIDTH-1:0] hold_word_r;
    logic [WIDTH-1:0] shift_r;
    logic [CNT_W-1:0] cnt_r;

    // Next-state values
    logic [0:0]       state_nxt_s;
    logic             full_nxt_s;
    logic [WIDTH-1:0] hold_word_nxt_s;
    logic [WIDTH-1:0] shift_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;

    // Control decodes
    logic             accept_s;
    logic             load_s;
    logic             last_bit_s;
    logic             out_bit_s;
    logic [WIDTH-1:0] shifted_s;

    // Output-end bit and the register after one shift toward that end
    always_comb begin
        if (MSB_FIRST != 0) begin
            out_bit_s = shift_r[WIDTH-1];
            shifted_s = {shift_r[WIDTH-2:0], 1'b0};
        end else begin
            out_bit_s = shift_r[0];
            shifted_s = {1'b0, shift_r[WIDTH-1:1]};
        end
    end

    // Handshake and move decodes. Acceptance needs the full flag clear and a
    // move needs it set, so the two can never fire in the same cycle.
    always_comb begin
        accept_s   = data_valid & ~full_r;
        last_bit_s = (cnt_r == CNT_LAST);
        load_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // An idle block loads a held word even while hold is high;
                // the hold only gates the shifting that follows.
                load_s = full_r;
            end
            ST_SHIFT: begin
                load_s = full_r & ~hold & last_bit_s;
            end
            default: begin
                load_s = 1'b0;
            end
        endcase
    end

    // Holding register and full flag next values
    always_comb begin
        full_nxt_s      = full_r;
        hold_word_nxt_s = hold_word_r;
        if (load_s) begin
            full_nxt_s = 1'b0;
        end else if (accept_s) begin
            full_nxt_s      = 1'b1;
            hold_word_nxt_s = data_in;
        end else begin
            full_nxt_s      = full_r;
            hold_word_nxt_s = hold_word_r;
        end
    end

    // Shift register, bit counter and state next values
    always_comb begin
        state_nxt_s = state_r;
        shift_nxt_s = shift_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (load_s) begin
                    state_nxt_s = ST_SHIFT;
                    shift_nxt_s = hold_word_r;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (hold) begin
                    // Everything frozen so no bit is dropped or repeated.
                    state_nxt_s = ST_SHIFT;
                end else if (last_bit_s) begin
                    if (full_r) begin
                        // Chain straight into the next word: no idle cycle.
                        state_nxt_s = ST_SHIFT;
                        shift_nxt_s = hold_word_r;
                        cnt_nxt_s   = CNT_ZERO;
                    end else begin
                        state_nxt_s = ST_IDLE;
                        shift_nxt_s = WORD_ZERO;
                        cnt_nxt_s   = CNT_ZERO;
                    end
                end else begin
                    state_nxt_s = ST_SHIFT;
                    shift_nxt_s = shifted_s;
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                shift_nxt_s = WORD_ZERO;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // Holding register and full flag; reset discards any held word at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_r      <= 1'b0;
            hold_word_r <= WORD_ZERO;
        end else begin
            full_r      <= full_nxt_s;
            hold_word_r <= hold_word_nxt_s;
        end
    end

    // Shift path state; reset discards the word in flight at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            shift_r <= WORD_ZERO;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            shift_r <= shift_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Output decode. data_ready comes only from the full flag (masked during
    // reset so it reads 0 while reset is held); valid_out follows hold in the
    // same cycle so the downstream detector never sees a frozen bit twice.
    always_comb begin
        data_ready = ~full_r & ~reset;
        busy       = (state_r == ST_SHIFT) | full_r;
        if (state_r == ST_SHIFT) begin
            d_out     = out_bit_s;
            valid_out = ~hold;
        end else begin
            d_out     = 1'b0;
            valid_out = 1'b0;
        end
    end

endmodule

// File: tb/tb_pattern_serializer.sv
// -----------------------------------------------------------------------------
// tb_pattern_serializer
//
// Directed bench for pattern_serializer. dut_msb uses the default MSB-first
// order, dut_lsb uses MSB_FIRST=0. Serial bits are collected at the falling
// edge into queues; inputs are driven 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_pattern_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;
    logic       hold;
    logic       hold_req = 1'b0;
    logic       rand_hold_en = 1'b0;
    logic       data_ready, d_out, valid_out, busy;

    logic [7:0] data_in2 = 8'h00;
    logic       data_valid2 = 1'b0;
    logic       hold2 = 1'b0;
    logic       data_ready2, d_out2, valid_out2, busy2;

    int checks = 0;
    int failures = 0;

    logic obs_q[$];
    logic obs2_q[$];
    logic ref_q[$];

    pattern_serializer #(.WIDTH(8), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .hold(hold), .d_out(d_out),
        .valid_out(valid_out), .busy(busy)
    );

    pattern_serializer #(.WIDTH(8), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .reset(reset), .data_in(data_in2), .data_valid(data_valid2),
        .data_ready(data_ready2), .hold(hold2), .d_out(d_out2),
        .valid_out(valid_out2), .busy(busy2)
    );

    // Hold driver: either the directed request or a random 1-in-4 pause
    always @(posedge clk) begin
        #2;
        if (rand_hold_en) hold = ($urandom_range(0, 3) == 0);
        else              hold = hold_req;
    end

    // Serial bit collectors
    always @(negedge clk) begin
        if (valid_out === 1'b1) obs_q.push_back(d_out);
        if (valid_out2 === 1'b1) obs2_q.push_back(d_out2);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word to dut_msb once it is ready; junk on data_in afterwards
    task automatic send(input logic [7:0] w);
        int n;
        n = 0;
        while (data_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (data_ready !== 1'b1) check_eq("send_ready", data_ready, 1);
        data_in    = w;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        data_in    = 8'($urandom);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 400) begin
            tick();
            n++;
        end
        if (busy !== 1'b0) check_eq(tag, busy, 0);
    endtask

    // Overlapping occurrences of 1011 in the observed stream from start
    function automatic int count_pat(input int start);
        int c;
        logic [3:0] sh;
        c  = 0;
        sh = 4'b0000;
        for (int i = start; i < obs_q.size(); i++) begin
            sh = {sh[2:0], obs_q[i]};
            if ((i - start) >= 3 && sh == 4'b1011) c++;
        end
        return c;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int n;
        int bad;
        int gold_cnt;
        int gfill;
        logic [3:0] gsh;
        logic [7:0] w;
        logic [7:0] got;
        logic [7:0] b;

        // ---------------- reset state ----------------
        repeat (3) tick();
        check_eq("rst_d_out", d_out, 0);
        check_eq("rst_valid_out", valid_out, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_data_ready", data_ready, 0);
        check_eq("rst_data_ready_lsb", data_ready2, 0);
        reset = 1'b0;
        #1;
        check_eq("post_rst_ready", data_ready, 1);
        check_eq("post_rst_ready_lsb", data_ready2, 1);

        // ---------------- single word 8'hB4 ----------------
        w          = 8'hB4;
        data_in    = w;
        data_valid = 1'b1;
        tick();                               // edge N: accepted
        data_valid = 1'b0;
        @(negedge clk);
        check_eq("single_wait_valid", valid_out, 0);
        check_eq("single_wait_busy", busy, 1);
        check_eq("single_wait_ready", data_ready, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_eq("single_valid", valid_out, 1);
            check_eq("single_bit", d_out, w[7-i]);
        end
        @(negedge clk);
        check_eq("single_end_valid", valid_out, 0);
        check_eq("single_end_busy", busy, 0);
        check_eq("single_end_d_out", d_out, 0);

        // ---------------- back-to-back FF then 00 ----------------
        tick();
        data_in    = 8'hFF;
        data_valid = 1'b1;
        tick();                               // edge N: FF accepted
        data_in = 8'h00;
        @(negedge clk);
        check_eq("b2b_wait_valid", valid_out, 0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 0) check_eq("b2b_ready_free", data_ready, 1);
            if (i == 1) begin
                check_eq("b2b_ready_full", data_ready, 0);
                data_valid = 1'b0;
            end
            check_eq("b2b_valid", valid_out, 1);
            check_eq("b2b_bit", d_out, (i < 8) ? 1 : 0);
        end
        @(negedge clk);
        check_eq("b2b_end_valid", valid_out, 0);
        check_eq("b2b_end_busy", busy, 0);

        // ---------------- hold pause on 8'hA5 ----------------
        tick();
        base = obs_q.size();
        send(8'hA5);
        n = 0;
        while ((obs_q.size() - base) < 3 && n < 50) begin
            tick();
            n++;
        end
        check_eq("hold_three_bits", obs_q.size() - base, 3);
        hold_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("hold_valid", valid_out, 0);
            check_eq("hold_busy", busy, 1);
        end
        hold_req = 1'b0;
        wait_idle("hold_idle");
        check_eq("hold_count", obs_q.size() - base, 8);
        got = 8'h00;
        for (int j = 0; j < 8 && (base + j) < obs_q.size(); j++) got[7-j] = obs_q[base+j];
        check_eq("hold_stream", got, 8'hA5);

        // ---------------- LSB-first 8'h01 ----------------
        data_in2    = 8'h01;
        data_valid2 = 1'b1;
        tick();
        data_valid2 = 1'b0;
        n = 0;
        while (busy2 !== 1'b0 && n < 50) begin
            tick();
            n++;
        end
        check_eq("lsb_idle", busy2, 0);
        check_eq("lsb_count", obs2_q.size(), 8);
        if (obs2_q.size() > 0) check_eq("lsb_first_bit", obs2_q[0], 1);
        got = 8'h00;
        for (int j = 0; j < 8 && j < obs2_q.size(); j++) got[j] = obs2_q[j];
        check_eq("lsb_word", got, 8'h01);

        // ---------------- reset mid-word ----------------
        base = obs_q.size();
        send(8'hC3);
        send(8'h5A);
        n = 0;
        while ((obs_q.size() - base) < 4 && n < 50) begin
            tick();
            n++;
        end
        check_eq("midrst_four_bits", obs_q.size() - base, 4);
        check_eq("midrst_word_held", data_ready, 0);
        reset = 1'b1;
        #1;
        check_eq("midrst_valid", valid_out, 0);
        check_eq("midrst_d_out", d_out, 0);
        check_eq("midrst_busy", busy, 0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        check_eq("midrst_ready", data_ready, 1);
        base = obs_q.size();
        repeat (20) tick();
        check_eq("midrst_no_bits", obs_q.size() - base, 0);
        check_eq("midrst_busy_after", busy, 0);

        // ---------------- random stream with random hold ----------------
        rand_hold_en = 1'b1;
        base     = obs_q.size();
        gold_cnt = 0;
        gfill    = 0;
        gsh      = 4'b0000;
        for (int k = 0; k < 540; k++) begin
            b = 8'($urandom_range(0, 255));
            for (int j = 7; j >= 0; j--) begin
                ref_q.push_back(b[j]);
                gsh = {gsh[2:0], b[j]};
                gfill++;
                if (gfill >= 4 && gsh == 4'b1011) gold_cnt++;
            end
            send(b);
        end
        wait_idle("rand_idle");
        rand_hold_en = 1'b0;
        check_eq("rand_count", obs_q.size() - base, ref_q.size());
        bad = 0;
        for (int i = 0; i < ref_q.size() && (base + i) < obs_q.size(); i++) begin
            if (obs_q[base+i] !== ref_q[i]) bad++;
        end
        check_eq("rand_bit_errors", bad, 0);
        check_eq("rand_detector", count_pat(base), gold_cnt);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
